// File: rtl/uart_flash_cmd_seq.sv
// UART command sequencer: parses "R" + AAAAAA + LL + CR and streams flash bytes to the transmit stage.
// Optional echo of parse-phase bytes (and '?' on error) when UART_FLASH_CMD_ECHO_EN is defined.
module uart_flash_cmd_seq #(
  parameter logic [23:0] BASE_ADDR = 24'h400000,
  parameter logic [7:0]  ESC_CHAR  = 8'h1B
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_read,
  output logic        flash_read,
  output logic [23:0] flash_addr,
  input  logic        flash_ready,
  input  logic [7:0]  flash_data,
  output logic [7:0]  out_data,
  output logic        out_write,
  input  logic        out_ready,
  output logic        busy,
  output logic        err
);

  localparam int unsigned AW = 24;
  localparam int unsigned DW = 8;
  localparam int unsigned CW = 9;
  localparam int unsigned NW = 3;

  localparam logic [DW-1:0] CHAR_CR = 8'h0D;
  localparam logic [DW-1:0] CHAR_LF = 8'h0A;

  typedef enum logic [3:0] {
    IDLE, ADDR, LEN, EOL, FREQ, FWAIT, TXREQ, TXHOLD, TXWAIT
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] byte_q, byte_d;
  logic          pend_q, pend_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] len_q, len_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [NW-1:0] dig_q, dig_d;
  logic          abort_q, abort_d;
  logic          rx_read_q, rx_read_d;
  logic          flash_read_q, flash_read_d;
  logic [AW-1:0] flash_addr_q, flash_addr_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic          out_write_q, out_write_d;
  logic          busy_q, busy_d;
  logic          err_q, err_d;
`ifdef UART_FLASH_CMD_ECHO_EN
  localparam logic [DW-1:0] CHAR_QM = 8'h3F;
  state_t        ret_q, ret_d;
  logic          ret_pend_q, ret_pend_d;
`endif

  logic          take_c;
  logic          parse_st_c;
  logic          parse_err_c;
  logic [4:0]    hex_c;

  // {valid, nibble} for an ASCII hex digit
  function automatic logic [4:0] hex_dec(input logic [7:0] c);
    if (c >= 8'h30 && c <= 8'h39)      hex_dec = {1'b1, 4'(c - 8'h30)};
    else if (c >= 8'h41 && c <= 8'h46) hex_dec = {1'b1, 4'(c - 8'h37)};
    else if (c >= 8'h61 && c <= 8'h66) hex_dec = {1'b1, 4'(c - 8'h57)};
    else                               hex_dec = 5'd0;
  endfunction

  always_comb begin
    state_d      = state_q;
    byte_d       = byte_q;
    pend_d       = pend_q;
    addr_d       = addr_q;
    len_d        = len_q;
    cnt_d        = cnt_q;
    dig_d        = dig_q;
    abort_d      = abort_q;
    flash_addr_d = flash_addr_q;
    out_data_d   = out_data_q;
    busy_d       = busy_q;
    rx_read_d    = 1'b0;
    flash_read_d = 1'b0;
    out_write_d  = 1'b0;
    err_d        = 1'b0;
    parse_err_c  = 1'b0;
`ifdef UART_FLASH_CMD_ECHO_EN
    ret_d        = ret_q;
    ret_pend_d   = ret_pend_q;
`endif
    take_c     = rx_valid && !rx_read_q;
    parse_st_c = state_q inside {IDLE, ADDR, LEN, EOL};
    hex_c      = hex_dec(byte_q);

    // During a burst every byte is drained; only ESC has an effect
    if (busy_q) begin
      if (take_c) begin
        rx_read_d = 1'b1;
        if (rx_data == ESC_CHAR) abort_d = 1'b1;
      end
    end else if (parse_st_c && !pend_q && take_c) begin
      rx_read_d = 1'b1;
      byte_d    = rx_data;
`ifdef UART_FLASH_CMD_ECHO_EN
      out_data_d = rx_data;
      ret_d      = state_q;
      ret_pend_d = 1'b1;
      state_d    = TXREQ;
`else
      pend_d     = 1'b1;
`endif
    end

    case (state_q)
      IDLE: if (pend_q) begin
        pend_d = 1'b0;
        if (byte_q == 8'h52 || byte_q == 8'h72) begin
          state_d = ADDR;
          dig_d   = '0;
        end else if (byte_q != CHAR_CR && byte_q != CHAR_LF) begin
          parse_err_c = 1'b1;
        end
      end
      ADDR: if (pend_q) begin
        pend_d = 1'b0;
        if (hex_c[4]) begin
          addr_d = {addr_q[AW-5:0], hex_c[3:0]};
          if (dig_q == 3'd5) begin
            dig_d   = '0;
            state_d = LEN;
          end else begin
            dig_d = NW'(dig_q + 3'd1);
          end
        end else begin
          parse_err_c = 1'b1;
        end
      end
      LEN: if (pend_q) begin
        pend_d = 1'b0;
        if (hex_c[4]) begin
          len_d = {len_q[3:0], hex_c[3:0]};
          if (dig_q == 3'd1) begin
            dig_d   = '0;
            state_d = EOL;
          end else begin
            dig_d = NW'(dig_q + 3'd1);
          end
        end else begin
          parse_err_c = 1'b1;
        end
      end
      EOL: if (pend_q) begin
        pend_d = 1'b0;
        if (byte_q == CHAR_CR) begin
          flash_addr_d = AW'(BASE_ADDR + addr_q);
          cnt_d        = (len_q == 8'd0) ? 9'd256 : CW'(len_q);
          busy_d       = 1'b1;
          abort_d      = 1'b0;
          state_d      = FREQ;
        end else begin
          parse_err_c = 1'b1;
        end
      end
      FREQ: begin
        flash_read_d = 1'b1;
        state_d      = FWAIT;
      end
      FWAIT: if (flash_ready) begin
        out_data_d = flash_data;
        state_d    = TXREQ;
      end
      TXREQ: if (out_ready) begin
        out_write_d = 1'b1;
        state_d     = TXHOLD;
      end
      // out_ready still reflects the pre-write idle state here
      TXHOLD: state_d = TXWAIT;
      TXWAIT: if (out_ready) begin
        if (busy_q) begin
          flash_addr_d = AW'(flash_addr_q + 24'd1);
          cnt_d        = CW'(cnt_q - 9'd1);
          if (cnt_q == 9'd1 || abort_q) begin
            busy_d  = 1'b0;
            abort_d = 1'b0;
            state_d = IDLE;
          end else begin
            state_d = FREQ;
          end
        end
`ifdef UART_FLASH_CMD_ECHO_EN
        else begin
          state_d = ret_q;
          pend_d  = ret_pend_q;
        end
`endif
      end
      default: state_d = IDLE;
    endcase

    if (parse_err_c) begin
      err_d   = 1'b1;
      state_d = IDLE;
`ifdef UART_FLASH_CMD_ECHO_EN
      out_data_d = CHAR_QM;
      ret_d      = IDLE;
      ret_pend_d = 1'b0;
      state_d    = TXREQ;
`endif
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      byte_q       <= '0;
      pend_q       <= 1'b0;
      addr_q       <= '0;
      len_q        <= '0;
      cnt_q        <= '0;
      dig_q        <= '0;
      abort_q      <= 1'b0;
      rx_read_q    <= 1'b0;
      flash_read_q <= 1'b0;
      flash_addr_q <= BASE_ADDR;
      out_data_q   <= '0;
      out_write_q  <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
`ifdef UART_FLASH_CMD_ECHO_EN
      ret_q        <= IDLE;
      ret_pend_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      byte_q       <= byte_d;
      pend_q       <= pend_d;
      addr_q       <= addr_d;
      len_q        <= len_d;
      cnt_q        <= cnt_d;
      dig_q        <= dig_d;
      abort_q      <= abort_d;
      rx_read_q    <= rx_read_d;
      flash_read_q <= flash_read_d;
      flash_addr_q <= flash_addr_d;
      out_data_q   <= out_data_d;
      out_write_q  <= out_write_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
`ifdef UART_FLASH_CMD_ECHO_EN
      ret_q        <= ret_d;
      ret_pend_q   <= ret_pend_d;
`endif
    end
  end

  assign rx_read    = rx_read_q;
  assign flash_read = flash_read_q;
  assign flash_addr = flash_addr_q;
  assign out_data   = out_data_q;
  assign out_write  = out_write_q;
  assign busy       = busy_q;
  assign err        = err_q;

endmodule

// File: tb/tb_uart_flash_cmd_seq.sv
// Bench for uart_flash_cmd_seq: uart_rx / flash / uart_tx models with an address and data scoreboard.
module tb_uart_flash_cmd_seq;

  localparam logic [23:0] BASE = 24'h400000;

  logic        clk = 1'b0;
  logic        rstn;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_read;
  logic        flash_read;
  logic [23:0] flash_addr;
  logic        flash_ready;
  logic [7:0]  flash_data;
  logic [7:0]  out_data;
  logic        out_write;
  logic        out_ready;
  logic        busy;
  logic        err;

  int tests = 0;
  int fails = 0;
  int n_reads = 0;
  int n_writes = 0;
  int n_err = 0;
  int rst_epoch = 0;
  int fl_lat = 2;
  int gap = 0;
  bit rx_drop = 1'b0;
  bit hold_next = 1'b0;
  int r0, w0, e0, dw;

  logic [7:0]  rx_q[$];
  logic [23:0] exp_addr[$];
  logic [7:0]  exp_out[$];

  logic [23:0] fl_a;
  int          fl_n;
  int          fl_ep;
  int          tx_n;

  uart_flash_cmd_seq dut (
    .clk         (clk),
    .rstn        (rstn),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_read     (rx_read),
    .flash_read  (flash_read),
    .flash_addr  (flash_addr),
    .flash_ready (flash_ready),
    .flash_data  (flash_data),
    .out_data    (out_data),
    .out_write   (out_write),
    .out_ready   (out_ready),
    .busy        (busy),
    .err         (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic expect_burst(input logic [23:0] a, input int n);
    logic [23:0] x;
    for (int i = 0; i < n; i++) begin
      x = 24'(BASE + a + 24'(i));
      exp_addr.push_back(x);
      exp_out.push_back(x[7:0]);
    end
  endtask

  task automatic send(input string s);
    int k;
    for (int i = 0; i < s.len(); i++) rx_q.push_back(s[i]);
    k = 0;
    while ((rx_q.size() != 0 || rx_valid || rx_drop) && k < 50 * s.len() + 50) begin
      @(posedge clk); #2;
      k++;
    end
    check("send_drained", 32'(rx_q.size() != 0 || rx_valid), 32'd0);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int k;
    k = 0;
    while (busy && k < budget) begin
      @(posedge clk); #2;
      k++;
    end
    check(tag, 32'(busy), 32'd0);
  endtask

  task automatic wait_writes(input string tag, input int target, input int budget);
    int k;
    k = 0;
    while (n_writes < target && k < budget) begin
      @(posedge clk); #2;
      k++;
    end
    check(tag, 32'(n_writes >= target), 32'd1);
  endtask

  // uart_rx model: valid drops one cycle after the consume pulse
  initial begin
    forever begin
      @(posedge clk); #1;
      if (rx_drop) begin
        rx_valid = 1'b0;
        rx_drop  = 1'b0;
        gap      = 2;
      end else if (rx_valid && rx_read) begin
        rx_drop = 1'b1;
      end else if (!rx_valid && gap == 0 && rx_q.size() != 0) begin
        rx_data  = rx_q.pop_front();
        rx_valid = 1'b1;
      end else if (gap > 0) begin
        gap--;
      end
    end
  end

  // Flash model: returns addr[7:0] fl_lat cycles after the request
  initial begin
    forever begin
      @(posedge clk); #1;
      if (flash_read) begin
        fl_a  = flash_addr;
        fl_n  = fl_lat;
        fl_ep = rst_epoch;
        repeat (fl_n) @(posedge clk);
        #1;
        flash_data  = fl_a[7:0];
        flash_ready = 1'b1;
        if (fl_ep == rst_epoch) check("flash_addr_stable", 32'(flash_addr), 32'(fl_a));
        @(posedge clk); #1;
        flash_ready = 1'b0;
      end
    end
  end

  // uart_tx model: ready drops after a write, optionally for a long hold
  initial begin
    forever begin
      @(posedge clk); #1;
      if (out_write) begin
        out_ready = 1'b0;
        tx_n      = hold_next ? 100 : 3;
        hold_next = 1'b0;
        repeat (tx_n) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    end
  end

  // Scoreboard monitor
  initial begin
    forever begin
      @(posedge clk); #1;
      if (flash_read) begin
        n_reads++;
        check("read_expected", 32'(exp_addr.size() != 0), 32'd1);
        if (exp_addr.size() != 0) check("flash_addr", 32'(flash_addr), 32'(exp_addr.pop_front()));
      end
      if (out_write) begin
        n_writes++;
        check("write_expected", 32'(exp_out.size() != 0), 32'd1);
        if (exp_out.size() != 0) check("out_data", 32'(out_data), 32'(exp_out.pop_front()));
      end
      if (err) n_err++;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn        = 1'b0;
    rx_valid    = 1'b0;
    rx_data     = 8'h00;
    flash_ready = 1'b0;
    flash_data  = 8'h00;
    out_ready   = 1'b1;
    cycles(3);
    check("rst_rx_read", 32'(rx_read), 32'd0);
    check("rst_flash_read", 32'(flash_read), 32'd0);
    check("rst_flash_addr", 32'(flash_addr), 32'(BASE));
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_write", 32'(out_write), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rstn = 1'b1;
    cycles(2);

    // Basic 3-byte burst
    r0 = n_reads; w0 = n_writes; e0 = n_err;
    expect_burst(24'h000000, 3);
    send("R00000003\015");
    check("t1_busy_high", 32'(busy), 32'd1);
    wait_idle("t1_idle", 300);
    check("t1_reads", 32'(n_reads - r0), 32'd3);
    check("t1_writes", 32'(n_writes - w0), 32'd3);
    check("t1_queue_empty", 32'(exp_out.size()), 32'd0);
    check("t1_no_err", 32'(n_err - e0), 32'd0);

    // Top-of-space addresses and 24-bit wrap
    r0 = n_reads;
    expect_burst(24'hBFFFFE, 2);
    send("RBFFFFE02\015");
    wait_idle("t2a_idle", 300);
    expect_burst(24'hBFFFFF, 2);
    send("rbfffff02\015");
    wait_idle("t2b_idle", 300);
    check("t2_reads", 32'(n_reads - r0), 32'd4);
    check("t2_queue_empty", 32'(exp_addr.size()), 32'd0);

    // LL=00 means 256 bytes
    r0 = n_reads; w0 = n_writes;
    expect_burst(24'h000010, 256);
    send("R00001000\015");
    wait_idle("t3_idle", 8000);
    check("t3_reads", 32'(n_reads - r0), 32'd256);
    check("t3_writes", 32'(n_writes - w0), 32'd256);

    // Parse errors, ignored line endings, recovery
    e0 = n_err;
    send("R0000G");
    cycles(3);
    check("t4_err_on_G", 32'(n_err - e0), 32'd1);
    check("t4_not_busy", 32'(busy), 32'd0);
    send("\012\015");
    cycles(3);
    check("t4_crlf_ignored", 32'(n_err - e0), 32'd1);
    send("R12\015");
    cycles(3);
    check("t4_err_short_cr", 32'(n_err - e0), 32'd2);
    r0 = n_reads; w0 = n_writes;
    expect_burst(24'h000042, 1);
    send("R00004201\015");
    wait_idle("t4_idle", 300);
    check("t4_reads", 32'(n_reads - r0), 32'd1);
    check("t4_writes", 32'(n_writes - w0), 32'd1);

    // ESC abort mid-burst
    r0 = n_reads; w0 = n_writes; e0 = n_err;
    expect_burst(24'h000000, 255);
    send("R000000FF\015");
    wait_writes("t5_fourth_write", w0 + 4, 400);
    send("\033");
    wait_idle("t5_idle", 400);
    dw = n_writes - w0;
    check("t5_esc_count_ok", 32'(dw >= 4 && dw <= 5), 32'd1);
    check("t5_reads_eq_writes", 32'(n_reads - r0), 32'(dw));
    check("t5_no_err", 32'(n_err - e0), 32'd0);
    exp_addr.delete();
    exp_out.delete();
    r0 = n_reads; w0 = n_writes;
    expect_burst(24'h000100, 2);
    send("R00010002\015");
    wait_idle("t5_next_idle", 300);
    check("t5_next_writes", 32'(n_writes - w0), 32'd2);

    // Downstream held not-ready stalls the next flash read
    r0 = n_reads; w0 = n_writes;
    hold_next = 1'b1;
    expect_burst(24'h000200, 2);
    send("R00020002\015");
    wait_writes("t6_first_write", w0 + 1, 100);
    cycles(90);
    check("t6_stalled_reads", 32'(n_reads - r0), 32'd1);
    check("t6_busy_held", 32'(busy), 32'd1);
    wait_idle("t6_idle", 300);
    check("t6_reads", 32'(n_reads - r0), 32'd2);
    check("t6_writes", 32'(n_writes - w0), 32'd2);

    // Asynchronous reset while waiting on the flash
    fl_lat = 20;
    r0 = n_reads;
    expect_burst(24'h000300, 5);
    send("R00030005\015");
    while (n_reads == r0 && busy) begin
      @(posedge clk); #2;
    end
    cycles(3);
    #1;
    rst_epoch++;
    rstn = 1'b0;
    #1;
    check("mid_rst_rx_read", 32'(rx_read), 32'd0);
    check("mid_rst_flash_read", 32'(flash_read), 32'd0);
    check("mid_rst_flash_addr", 32'(flash_addr), 32'(BASE));
    check("mid_rst_out_data", 32'(out_data), 32'd0);
    check("mid_rst_out_write", 32'(out_write), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_err", 32'(err), 32'd0);
    exp_addr.delete();
    exp_out.delete();
    w0 = n_writes;
    cycles(2);
    rstn   = 1'b1;
    fl_lat = 2;
    cycles(40);
    check("post_rst_no_write", 32'(n_writes - w0), 32'd0);
    check("post_rst_idle", 32'(busy), 32'd0);
    expect_burst(24'h000400, 1);
    send("R00040001\015");
    wait_idle("post_rst_cmd_idle", 300);
    check("post_rst_cmd_writes", 32'(n_writes - w0), 32'd1);
    check("post_rst_queue_empty", 32'(exp_out.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
